// File: rtl/run_controller_pkg.sv
// Shared encodings for the core run/reset sequencer.
package run_controller_pkg;

  typedef enum logic [2:0] {
    ST_HOLD = 3'd0,
    ST_IDLE = 3'd1,
    ST_RUN  = 3'd2,
    ST_STEP = 3'd3,
    ST_HALT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_STOP  = 2'd1,
    CAUSE_LIMIT = 2'd2,
    CAUSE_BKPT  = 2'd3
  } cause_e;

endpackage

// File: rtl/run_controller_sat_counter.sv
// Up-counter that sticks at all-ones; sync clear wins over enable.
module run_controller_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)                         count_d = '0;
    else if (en && (count_q != '1))  count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/run_controller.sv
// Run/reset sequencer for the core: reset hold, free-run/single-step gating,
// cycle counting and halt on stop, cycle limit or PC breakpoint.
module run_controller
  import run_controller_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int PC_W       = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             soft_rst,
  input  logic             start,
  input  logic             step,
  input  logic             stop,
  input  logic [CNT_W-1:0] limit,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             core_reset,
  output logic             run,
  output logic [CNT_W-1:0] cycle_count,
  output logic             halted,
  output logic [1:0]       halt_cause
);

  localparam int                HOLD_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

  state_e            state_q, state_d;
  cause_e            cause_q, cause_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              resumed_q, resumed_d;
  logic              core_reset_q, core_reset_d;
  logic              run_q, run_d;
  logic              halted_q, halted_d;
  logic              lim_hit, bp_hit;

  // >= rather than == so a resume past the limit re-halts after one cycle.
  assign lim_hit = (limit != '0) && (cycle_count >= (limit - CNT_W'(1)));
  // First cycle after resuming from HALT may sit on the breakpoint PC.
  assign bp_hit  = bp_en && (pc == bp_addr) && !resumed_q;

  always_comb begin
    state_d    = state_q;
    cause_d    = CAUSE_NONE;
    hold_cnt_d = '0;
    resumed_d  = 1'b0;
    if (soft_rst) begin
      state_d = ST_HOLD;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) state_d    = ST_IDLE;
          else                         hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
        ST_IDLE: begin
          if (start)     state_d = ST_RUN;
          else if (step) state_d = ST_STEP;
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_HALT;
            cause_d = CAUSE_STOP;
          end else if (lim_hit) begin
            state_d = ST_HALT;
            cause_d = CAUSE_LIMIT;
          end else if (bp_hit) begin
            state_d = ST_HALT;
            cause_d = CAUSE_BKPT;
          end
        end
        ST_STEP: begin
          if (lim_hit) begin
            state_d = ST_HALT;
            cause_d = CAUSE_LIMIT;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HALT: begin
          if (start) begin
            state_d   = ST_RUN;
            resumed_d = 1'b1;
          end else if (step) begin
            state_d = ST_STEP;
          end else begin
            cause_d = cause_q;
          end
        end
        default: state_d = ST_HOLD;
      endcase
    end
    core_reset_d = (state_d == ST_HOLD);
    run_d        = (state_d == ST_RUN) || (state_d == ST_STEP);
    halted_d     = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_HOLD;
      cause_q      <= CAUSE_NONE;
      hold_cnt_q   <= '0;
      resumed_q    <= 1'b0;
      core_reset_q <= 1'b1;
      run_q        <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cause_q      <= cause_d;
      hold_cnt_q   <= hold_cnt_d;
      resumed_q    <= resumed_d;
      core_reset_q <= core_reset_d;
      run_q        <= run_d;
      halted_q     <= halted_d;
    end
  end

  run_controller_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst),
    .en    (run_q),
    .clr   (soft_rst),
    .count (cycle_count)
  );

  assign core_reset = core_reset_q;
  assign run        = run_q;
  assign halted     = halted_q;
  assign halt_cause = cause_q;

endmodule

// File: tb/tb_run_controller.sv
// Randomized + directed bench for run_controller against a behavioural model.
module tb_run_controller;

  localparam int CNT_W      = 8;
  localparam int PC_W       = 8;
  localparam int RST_CYCLES = 2;
  localparam int MAXC       = (1 << CNT_W) - 1;

  localparam int M_HOLD = 0, M_IDLE = 1, M_RUN = 2, M_STEP = 3, M_HALT = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             soft_rst = 1'b0, start = 1'b0, step = 1'b0, stop = 1'b0, bp_en = 1'b0;
  logic [CNT_W-1:0] limit = '0;
  logic [PC_W-1:0]  bp_addr = '0, pc = '0;
  logic             core_reset, run, halted;
  logic [CNT_W-1:0] cycle_count;
  logic [1:0]       halt_cause;

  int checks = 0, errors = 0;
  int m_mode, m_hold_left, m_cnt, m_cause;
  bit m_fresh;
  bit pc_auto = 1'b0;
  int nrun;

  always #5 clk = ~clk;

  run_controller #(.CNT_W(CNT_W), .PC_W(PC_W), .RST_CYCLES(RST_CYCLES)) dut (
    .clk(clk), .rst(rst), .soft_rst(soft_rst), .start(start), .step(step), .stop(stop),
    .limit(limit), .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc),
    .core_reset(core_reset), .run(run), .cycle_count(cycle_count),
    .halted(halted), .halt_cause(halt_cause)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = M_HOLD; m_hold_left = RST_CYCLES; m_cnt = 0; m_cause = 0; m_fresh = 1'b0;
  endfunction

  // One clock of the spec rules, using the inputs present at the edge.
  function automatic void model_edge();
    bit running = (m_mode == M_RUN) || (m_mode == M_STEP);
    bit reach   = (limit != 0) && (m_cnt + 1 >= int'(limit));
    bit fresh   = m_fresh;
    m_fresh = 1'b0;
    if (running && m_cnt < MAXC) m_cnt = m_cnt + 1;
    if (soft_rst) begin
      m_mode = M_HOLD; m_hold_left = RST_CYCLES; m_cnt = 0; m_cause = 0;
    end else begin
      case (m_mode)
        M_HOLD: begin
          m_hold_left--;
          if (m_hold_left == 0) m_mode = M_IDLE;
        end
        M_IDLE: if (start) m_mode = M_RUN; else if (step) m_mode = M_STEP;
        M_RUN: begin
          if (stop)                                  begin m_mode = M_HALT; m_cause = 1; end
          else if (reach)                            begin m_mode = M_HALT; m_cause = 2; end
          else if (bp_en && pc == bp_addr && !fresh) begin m_mode = M_HALT; m_cause = 3; end
        end
        M_STEP: if (reach) begin m_mode = M_HALT; m_cause = 2; end else m_mode = M_IDLE;
        default: begin
          if (start)     begin m_mode = M_RUN; m_cause = 0; m_fresh = 1'b1; end
          else if (step) begin m_mode = M_STEP; m_cause = 0; end
        end
      endcase
    end
  endfunction

  task automatic compare_model();
    chk("core_reset", core_reset, m_mode == M_HOLD);
    chk("run", run, (m_mode == M_RUN) || (m_mode == M_STEP));
    chk("halted", halted, m_mode == M_HALT);
    chk("cycle_count", cycle_count, m_cnt);
    chk("halt_cause", halt_cause, m_cause);
  endtask

  task automatic tick();
    bit was_run;
    @(posedge clk);
    was_run = (m_mode == M_RUN) || (m_mode == M_STEP);
    model_edge();
    #1;
    compare_model();
    if (pc_auto && was_run) pc = pc + 1'b1;
  endtask

  task automatic pulse_start(); start = 1'b1; tick(); start = 1'b0; endtask

  task automatic do_soft_rst();
    soft_rst = 1'b1; tick(); soft_rst = 1'b0;
    chk("srst_core_reset", core_reset, 1);
    chk("srst_count", cycle_count, 0);
    tick(); tick();
  endtask

  task automatic run_to_halt(input string tag);
    nrun = 0;
    for (int i = 0; i < 60 && !halted; i++) begin
      if (run) nrun++;
      tick();
    end
    chk({tag, "_halted"}, halted, 1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_run", run, 0);
    chk("rst_count", cycle_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cause", halt_cause, 0);
    rst = 1'b1;
    tick(); chk("pwr_hold1", core_reset, 1);
    tick(); chk("pwr_hold2", core_reset, 0);
    chk("pwr_run", run, 0);

    // Cycle limit, then resume past the limit.
    limit = 8'd10;
    pulse_start();
    run_to_halt("lim");
    chk("lim_runs", nrun, 10);
    chk("lim_count", cycle_count, 10);
    chk("lim_cause", halt_cause, 2);
    pulse_start();
    chk("resume_run", run, 1);
    tick();
    chk("resume_halted", halted, 1);
    chk("resume_count", cycle_count, 11);
    chk("resume_cause", halt_cause, 2);

    // Breakpoint with pc advancing per run cycle.
    limit = '0;
    do_soft_rst();
    pc = '0; bp_addr = 8'h05; bp_en = 1'b1; pc_auto = 1'b1;
    pulse_start();
    run_to_halt("bp");
    chk("bp_cause", halt_cause, 3);
    chk("bp_count", cycle_count, 6);
    pc = 8'h05;
    pulse_start();
    repeat (3) tick();
    chk("bp_resume_run", run, 1);
    chk("bp_resume_halted", halted, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("bp_stop_cause", halt_cause, 1);
    pc_auto = 1'b0; bp_en = 1'b0;

    // Single step from IDLE.
    do_soft_rst();
    for (int k = 0; k < 3; k++) begin
      step = 1'b1; tick(); step = 1'b0;
      chk("step_run", run, 1);
      repeat (3) tick();
    end
    chk("step_count", cycle_count, 3);
    chk("step_halted", halted, 0);
    chk("step_run_low", run, 0);

    // Stop on the limit-th cycle outranks the limit.
    do_soft_rst();
    limit = 8'd4;
    pulse_start();
    repeat (3) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("prio_cause", halt_cause, 1);
    chk("prio_count", cycle_count, 4);

    // Soft reset mid-run.
    limit = '0;
    pulse_start();
    repeat (5) tick();
    soft_rst = 1'b1; tick(); soft_rst = 1'b0;
    chk("srun_run", run, 0);
    chk("srun_core_reset", core_reset, 1);
    chk("srun_count", cycle_count, 0);
    tick(); chk("srun_hold2", core_reset, 1);
    tick(); chk("srun_hold_done", core_reset, 0);

    // Counter saturation.
    pulse_start();
    repeat (MAXC + 20) tick();
    chk("sat_count", cycle_count, MAXC);
    chk("sat_run", run, 1);

    // Async reset between edges.
    #2 rst = 1'b0;
    #1;
    chk("arst_run", run, 0);
    chk("arst_core_reset", core_reset, 1);
    chk("arst_count", cycle_count, 0);
    chk("arst_halted", halted, 0);
    model_reset();
    @(posedge clk); #1; rst = 1'b1;
    tick(); tick();
    chk("arst_idle", core_reset, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      soft_rst = ($urandom_range(0, 63) == 0);
      start    = ($urandom_range(0, 7) == 0);
      step     = ($urandom_range(0, 7) == 0);
      stop     = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0)
        limit = ($urandom_range(0, 9) == 0) ? CNT_W'(MAXC) : CNT_W'($urandom_range(0, 20));
      bp_en   = 1'($urandom_range(0, 1));
      bp_addr = PC_W'($urandom_range(0, 7));
      pc      = PC_W'($urandom_range(0, 7));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
